// File: rtl/arb_pkg.sv
// Shared state encoding, requester ids and default sizing for the data bus arbiter.
package arb_pkg;

  localparam int DEF_DATA_W      = 8;
  localparam int DEF_ADDR_W      = 8;
  localparam int DEF_WAIT_STATES = 1;
  localparam int CNT_W           = 4;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  typedef enum logic {
    REQ_CORE = 1'b0,
    REQ_IO   = 1'b1
  } requester_e;

  // Round-robin: a tie goes to whoever was not served last.
  function automatic requester_e pick_winner(input logic req0, input logic req1,
                                             input requester_e last);
    if (req0 && req1) return (last == REQ_CORE) ? REQ_IO : REQ_CORE;
    return req1 ? REQ_IO : REQ_CORE;
  endfunction

endpackage

// File: rtl/wait_counter.sv
// Loadable down-counter timing the memory access window; zero flags the last cycle.
module wait_counter
  import arb_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             dec,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/data_bus_arbiter.sv
// Two-requester round-robin arbiter in front of a single wait-stated memory port.
//   state     | meaning
//   ST_IDLE   | no owner; sample requests, latch the winner's command
//   ST_ACCESS | memory enabled for WAIT_STATES+1 cycles, bus driven from latches
//   ST_DONE   | one-cycle Ack to the owner, grant still held
module data_bus_arbiter
  import arb_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int WAIT_STATES = DEF_WAIT_STATES
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_Req0,
  input  logic              i_Req1,
  input  logic              i_W_R0,
  input  logic              i_W_R1,
  input  logic [ADDR_W-1:0] i_Addr0,
  input  logic [ADDR_W-1:0] i_Addr1,
  input  logic [DATA_W-1:0] i_WData0,
  input  logic [DATA_W-1:0] i_WData1,
  output logic              o_Gnt0,
  output logic              o_Gnt1,
  output logic              o_Ack0,
  output logic              o_Ack1,
  output logic [DATA_W-1:0] o_RData,
  output logic              o_Mem_En,
  output logic              o_Mem_W_R,
  output logic [ADDR_W-1:0] o_Mem_Address_Data_Bus,
  output logic [DATA_W-1:0] o_Mem_DataOut_Bus,
  input  logic [DATA_W-1:0] i_Mem_DataIn_Bus,
  output logic              o_Busy
);

  localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(WAIT_STATES);

  logic [1:0] state;
  requester_e last_gnt;
  requester_e winner;
  logic       any_req;
  logic       cnt_load;
  logic       cnt_dec;
  logic       cnt_zero;

  assign any_req  = i_Req0 | i_Req1;
  assign winner   = pick_winner(i_Req0, i_Req1, last_gnt);
  assign cnt_load = (state == ST_IDLE) && any_req;
  assign cnt_dec  = (state == ST_ACCESS) && !cnt_zero;

  wait_counter u_wait_counter (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .dec      (cnt_dec),
    .load_val (WAIT_LOAD),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state                  <= ST_IDLE;
      last_gnt               <= REQ_IO;
      o_Gnt0                 <= 1'b0;
      o_Gnt1                 <= 1'b0;
      o_Ack0                 <= 1'b0;
      o_Ack1                 <= 1'b0;
      o_RData                <= '0;
      o_Mem_En               <= 1'b0;
      o_Mem_W_R              <= 1'b0;
      o_Mem_Address_Data_Bus <= '0;
      o_Mem_DataOut_Bus      <= '0;
      o_Busy                 <= 1'b0;
    end else begin
      o_Ack0 <= 1'b0;
      o_Ack1 <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (any_req) begin
            state                  <= ST_ACCESS;
            last_gnt               <= winner;
            o_Gnt0                 <= (winner == REQ_CORE);
            o_Gnt1                 <= (winner == REQ_IO);
            o_Mem_En               <= 1'b1;
            o_Busy                 <= 1'b1;
            o_Mem_W_R              <= (winner == REQ_IO) ? i_W_R1   : i_W_R0;
            o_Mem_Address_Data_Bus <= (winner == REQ_IO) ? i_Addr1  : i_Addr0;
            o_Mem_DataOut_Bus      <= (winner == REQ_IO) ? i_WData1 : i_WData0;
          end
        end
        ST_ACCESS: begin
          if (cnt_zero) begin
            state    <= ST_DONE;
            o_Mem_En <= 1'b0;
            o_Ack0   <= o_Gnt0;
            o_Ack1   <= o_Gnt1;
            if (!o_Mem_W_R) o_RData <= i_Mem_DataIn_Bus;
          end
        end
        ST_DONE: begin
          state  <= ST_IDLE;
          o_Gnt0 <= 1'b0;
          o_Gnt1 <= 1'b0;
          o_Busy <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
